// File: rtl/bb_credit_tx_gate_pkg.sv
// Shared types for the FC transmit BB_credit gate.
// The state encoding stays fixed because downstream debug taps decode it.
package bb_credit_tx_gate_pkg;

  localparam int BB_CREDIT_W = 16;

  typedef enum logic [1:0] {
    TXCR_IDLE  = 2'd0,
    TXCR_WAIT  = 2'd1,
    TXCR_GRANT = 2'd2,
    TXCR_SEND  = 2'd3
  } tx_credit_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bb_credit_tx_gate_credit_stall_timer.sv
// Saturating credit-starvation episode timer with a one-shot timeout pulse.
// Latency: pulse is combinational in the active cycle whose ordinal equals TIMEOUT; no backpressure.
module credit_stall_timer #(
  parameter int               TMR_W   = 24,
  parameter logic [TMR_W-1:0] TIMEOUT = 24'd1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  output logic timeout_pulse
);

  localparam logic [TMR_W-1:0] FIRE_AT = TIMEOUT - TMR_W'(1);
  localparam logic [TMR_W-1:0] CNT_MAX = '1;

  logic [TMR_W-1:0] count;
  logic             fired;

  // count holds the number of earlier active cycles in this episode
  assign timeout_pulse = active & ~fired & (count == FIRE_AT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      fired <= 1'b0;
    end else if (!active) begin
      count <= '0;
      fired <= 1'b0;
    end else begin
      if (count != CNT_MAX) count <= count + TMR_W'(1);
      if (timeout_pulse)    fired <= 1'b1;
    end
  end

endmodule

// File: rtl/bb_credit_tx_gate.sv
// Transmit-side BB_credit manager: gates frame starts on available credit, tracks starvation.
// Latency: request to grant 1 cycle; backpressure: a request waits in WAIT while credit is 0 or LOS.
module bb_credit_tx_gate
  import bb_credit_tx_gate_pkg::*;
#(
  parameter int                     CREDIT_W      = BB_CREDIT_W,
  parameter int                     STALL_TMR_W   = 24,
  parameter logic [STALL_TMR_W-1:0] STALL_TIMEOUT = 24'd1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iLINK_UP_EVENT,
  input  logic                iSFP_PHY_LOSIG,
  input  logic [CREDIT_W-1:0] iREG_CREDITSTART,
  input  logic                iFRAME_REQ,
  output logic                oFRAME_GNT,
  input  logic                iFRAME_EOF,
  input  logic                iRX_RRDY,
  input  logic                iSTATS_LATCH_CLR,
  output logic [CREDIT_W-1:0] oCREDIT_AVAIL,
  output logic                oCREDIT_ZERO,
  output logic                oSTALL_EVENT,
  output logic                oRRDY_OVERFLOW,
  output logic [31:0]         oINT_STATS_STALLTIME
);

  tx_credit_state_e    state, state_d;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] start_q;
  logic                start_chg_q;
  logic                rrdy_ovf_q;
  logic [31:0]         stall_acc;
  logic [31:0]         stall_stat;

  logic load, rrdy_vld, can_grant, gnt_take, in_wait;

  assign load      = iLINK_UP_EVENT | start_chg_q;
  assign rrdy_vld  = iRX_RRDY & ~iSFP_PHY_LOSIG;
  assign can_grant = (credit != '0) & ~iSFP_PHY_LOSIG;
  assign gnt_take  = (state_d == TXCR_GRANT);
  assign in_wait   = (state == TXCR_WAIT);

  always_comb begin
    state_d = state;
    case (state)
      TXCR_IDLE:  if (iFRAME_REQ) state_d = can_grant ? TXCR_GRANT : TXCR_WAIT;
      TXCR_WAIT:  if (!iFRAME_REQ) state_d = TXCR_IDLE;
                  else if (can_grant) state_d = TXCR_GRANT;
      TXCR_GRANT: state_d = iFRAME_EOF ? TXCR_IDLE : TXCR_SEND;
      TXCR_SEND:  if (iFRAME_EOF) state_d = TXCR_IDLE;
      default:    state_d = TXCR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TXCR_IDLE;
    else        state <= state_d;
  end

  // A reload wins outright, so a grant taken in the same cycle is not charged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit      <= '0;
      start_q     <= '0;
      start_chg_q <= 1'b0;
      rrdy_ovf_q  <= 1'b0;
    end else begin
      start_q     <= iREG_CREDITSTART;
      start_chg_q <= (iREG_CREDITSTART != start_q);
      rrdy_ovf_q  <= ~load & rrdy_vld & ~gnt_take & (credit >= iREG_CREDITSTART);
      if (load)
        credit <= iREG_CREDITSTART;
      else if (gnt_take && !rrdy_vld)
        credit <= credit - CREDIT_W'(1);
      else if (rrdy_vld && !gnt_take && (credit < iREG_CREDITSTART))
        credit <= credit + CREDIT_W'(1);
    end
  end

  // A WAIT cycle coinciding with the latch strobe is dropped rather than carried.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_acc  <= '0;
      stall_stat <= '0;
    end else if (iSTATS_LATCH_CLR) begin
      stall_stat <= stall_acc;
      stall_acc  <= '0;
    end else if (in_wait) begin
      stall_acc  <= sat_inc32(stall_acc);
    end
  end

  credit_stall_timer #(
    .TMR_W   (STALL_TMR_W),
    .TIMEOUT (STALL_TIMEOUT)
  ) u_stall_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .active        (in_wait),
    .timeout_pulse (oSTALL_EVENT)
  );

  assign oFRAME_GNT           = (state == TXCR_GRANT);
  assign oCREDIT_AVAIL        = credit;
  assign oCREDIT_ZERO         = (credit == '0);
  assign oRRDY_OVERFLOW       = rrdy_ovf_q;
  assign oINT_STATS_STALLTIME = stall_stat;

endmodule

// File: tb/tb_bb_credit_tx_gate.sv
// Directed bench for bb_credit_tx_gate; inputs driven and outputs sampled 1ns after posedge.
module tb_bb_credit_tx_gate;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        link_up = 1'b0;
  logic        losig = 1'b0;
  logic [15:0] cstart = 16'd0;
  logic        req = 1'b0;
  logic        gnt;
  logic        eof = 1'b0;
  logic        rrdy = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] credit;
  logic        czero;
  logic        stall_ev;
  logic        ovf;
  logic [31:0] stalltime;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bb_credit_tx_gate #(
    .CREDIT_W      (16),
    .STALL_TMR_W   (24),
    .STALL_TIMEOUT (24'd10)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .iLINK_UP_EVENT       (link_up),
    .iSFP_PHY_LOSIG       (losig),
    .iREG_CREDITSTART     (cstart),
    .iFRAME_REQ           (req),
    .oFRAME_GNT           (gnt),
    .iFRAME_EOF           (eof),
    .iRX_RRDY             (rrdy),
    .iSTATS_LATCH_CLR     (clr),
    .oCREDIT_AVAIL        (credit),
    .oCREDIT_ZERO         (czero),
    .oSTALL_EVENT         (stall_ev),
    .oRRDY_OVERFLOW       (ovf),
    .oINT_STATS_STALLTIME (stalltime)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cstart = 16'd3;
    repeat (2) tick();
    n_checks++; if (credit !== 16'd0) begin n_fail++; $display("FAIL reset_credit: got %0d expected 0", credit); end
    n_checks++; if (czero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %0b expected 1", czero); end
    n_checks++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %0b expected 0", gnt); end
    n_checks++; if (stall_ev !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b expected 0", stall_ev); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
    n_checks++; if (stalltime !== 32'd0) begin n_fail++; $display("FAIL reset_stalltime: got %0d expected 0", stalltime); end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic exp_g [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] exp_c [8] = '{16'd2, 16'd2, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
    int ngnt = 0;
    link_up = 1'b1; tick(); link_up = 1'b0;
    n_checks++; if (credit !== 16'd3) begin n_fail++; $display("FAIL linkup_load: got %0d expected 3", credit); end
    repeat (2) tick();
    req = 1'b1; eof = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (gnt === 1'b1) ngnt++;
      n_checks++; if (gnt !== exp_g[i]) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %0b expected %0b", i, gnt, exp_g[i]); end
      n_checks++; if (credit !== exp_c[i]) begin n_fail++; $display("FAIL b2b_credit[%0d]: got %0d expected %0d", i, credit, exp_c[i]); end
    end
    eof = 1'b0;
    n_checks++; if (ngnt != 3) begin n_fail++; $display("FAIL b2b_grant_count: got %0d expected 3", ngnt); end
    n_checks++; if (czero !== 1'b1) begin n_fail++; $display("FAIL b2b_zero: got %0b expected 1", czero); end
  endtask

  task automatic test_rrdy_wakeup();
    rrdy = 1'b1; tick(); rrdy = 1'b0;
    n_checks++; if (credit !== 16'd1) begin n_fail++; $display("FAIL wake_credit: got %0d expected 1", credit); end
    n_checks++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL wake_gnt_early: got %0b expected 0", gnt); end
    tick();
    n_checks++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL wake_gnt: got %0b expected 1", gnt); end
    n_checks++; if (credit !== 16'd0) begin n_fail++; $display("FAIL wake_credit_used: got %0d expected 0", credit); end
    req = 1'b0; eof = 1'b1; tick(); eof = 1'b0;
    n_checks++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL wake_gnt_once: got %0b expected 0", gnt); end
  endtask

  task automatic test_overflow();
    cstart = 16'd8; repeat (3) tick();
    n_checks++; if (credit !== 16'd8) begin n_fail++; $display("FAIL ovf_reload: got %0d expected 8", credit); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_idle: got %0b expected 0", ovf); end
    rrdy = 1'b1; tick(); rrdy = 1'b0;
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %0b expected 1", ovf); end
    n_checks++; if (credit !== 16'd8) begin n_fail++; $display("FAIL ovf_hold: got %0d expected 8", credit); end
    tick();
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle: got %0b expected 0", ovf); end
    req = 1'b1; eof = 1'b1; tick(); req = 1'b0;
    n_checks++; if (credit !== 16'd7) begin n_fail++; $display("FAIL ovf_dec: got %0d expected 7", credit); end
    tick(); eof = 1'b0;
    losig = 1'b1; rrdy = 1'b1; tick();
    n_checks++; if (credit !== 16'd7) begin n_fail++; $display("FAIL losig_rrdy_ignored: got %0d expected 7", credit); end
    losig = 1'b0; tick(); rrdy = 1'b0;
    n_checks++; if (credit !== 16'd8) begin n_fail++; $display("FAIL rrdy_inc: got %0d expected 8", credit); end
    tick();
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rrdy_inc_no_ovf: got %0b expected 0", ovf); end
  endtask

  task automatic test_grant_rrdy_same();
    cstart = 16'd2; repeat (3) tick();
    n_checks++; if (credit !== 16'd2) begin n_fail++; $display("FAIL same_reload: got %0d expected 2", credit); end
    req = 1'b1; eof = 1'b1; rrdy = 1'b1; tick(); req = 1'b0; rrdy = 1'b0;
    n_checks++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL same_gnt: got %0b expected 1", gnt); end
    n_checks++; if (credit !== 16'd2) begin n_fail++; $display("FAIL same_credit: got %0d expected 2", credit); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL same_no_ovf: got %0b expected 0", ovf); end
    tick(); eof = 1'b0;
    n_checks++; if (credit !== 16'd2) begin n_fail++; $display("FAIL same_credit_after: got %0d expected 2", credit); end
  endtask

  task automatic test_stall_stats();
    int nev = 0;
    clr = 1'b1; tick(); clr = 1'b0;
    cstart = 16'd0; repeat (3) tick();
    n_checks++; if (czero !== 1'b1) begin n_fail++; $display("FAIL stall_zero: got %0b expected 1", czero); end
    req = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (stall_ev === 1'b1) nev++;
      n_checks++; if (stall_ev !== (i == 10)) begin n_fail++; $display("FAIL stall_event[%0d]: got %0b expected %0b", i, stall_ev, (i == 10)); end
    end
    req = 1'b0; tick();
    n_checks++; if (nev != 1) begin n_fail++; $display("FAIL stall_event_count: got %0d expected 1", nev); end
    clr = 1'b1; tick(); clr = 1'b0;
    n_checks++; if (stalltime !== 32'd25) begin n_fail++; $display("FAIL stalltime_latched: got %0d expected 25", stalltime); end
    clr = 1'b1; tick(); clr = 1'b0;
    n_checks++; if (stalltime !== 32'd0) begin n_fail++; $display("FAIL stalltime_cleared: got %0d expected 0", stalltime); end
  endtask

  task automatic test_reload_mid_send();
    cstart = 16'd5; repeat (3) tick();
    n_checks++; if (credit !== 16'd5) begin n_fail++; $display("FAIL mid_reload5: got %0d expected 5", credit); end
    req = 1'b1; tick(); req = 1'b0;
    n_checks++; if (gnt !== 1'b1 || credit !== 16'd4) begin n_fail++; $display("FAIL mid_gnt: got gnt=%0b credit=%0d expected gnt=1 credit=4", gnt, credit); end
    tick();
    cstart = 16'd12; tick();
    n_checks++; if (credit !== 16'd4) begin n_fail++; $display("FAIL mid_credit_pre: got %0d expected 4", credit); end
    tick();
    n_checks++; if (credit !== 16'd12) begin n_fail++; $display("FAIL mid_credit_12: got %0d expected 12", credit); end
    n_checks++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL mid_no_regrant: got %0b expected 0", gnt); end
    eof = 1'b1; tick(); eof = 1'b0;
    n_checks++; if (credit !== 16'd12) begin n_fail++; $display("FAIL mid_no_recharge: got %0d expected 12", credit); end
    req = 1'b1; tick(); req = 1'b0;
    n_checks++; if (gnt !== 1'b1 || credit !== 16'd11) begin n_fail++; $display("FAIL mid_next_gnt: got gnt=%0b credit=%0d expected gnt=1 credit=11", gnt, credit); end
    eof = 1'b1; tick(); eof = 1'b0;
    // loss of signal holds off a grant even with credit available
    losig = 1'b1; req = 1'b1; tick();
    n_checks++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL losig_gate1: got %0b expected 0", gnt); end
    tick();
    n_checks++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL losig_gate2: got %0b expected 0", gnt); end
    losig = 1'b0; tick(); req = 1'b0;
    n_checks++; if (gnt !== 1'b1 || credit !== 16'd10) begin n_fail++; $display("FAIL losig_release: got gnt=%0b credit=%0d expected gnt=1 credit=10", gnt, credit); end
    tick();
    link_up = 1'b1; tick(); link_up = 1'b0;
    n_checks++; if (credit !== 16'd12 || gnt !== 1'b0) begin n_fail++; $display("FAIL linkup_in_send: got credit=%0d gnt=%0b expected credit=12 gnt=0", credit, gnt); end
    eof = 1'b1; tick(); eof = 1'b0;
    req = 1'b1; tick(); req = 1'b0;
    n_checks++; if (gnt !== 1'b1 || credit !== 16'd11) begin n_fail++; $display("FAIL post_linkup_gnt: got gnt=%0b credit=%0d expected gnt=1 credit=11", gnt, credit); end
    eof = 1'b1; tick(); eof = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_rrdy_wakeup();
    test_overflow();
    test_grant_rrdy_same();
    test_stall_stats();
    test_reload_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
